// File: rtl/reg_file_mp.sv
// Multi-port integer register file with optional write-to-read forwarding and a
// per-register busy scoreboard (reserved at issue, cleared at writeback).
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rg_rd_addr,
  output logic [NRD*XLEN-1:0] rg_rd_data,
  output logic [NRD-1:0]      rg_rd_busy,
  input  logic [NWR-1:0]      rg_wrt_en,
  input  logic [NWR*AW-1:0]   rg_wrt_dest,
  input  logic [NWR*XLEN-1:0] rg_wrt_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_dest
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_reg;

  logic [AW-1:0]   wr_dest [NWR];
  logic [XLEN-1:0] wr_data [NWR];

  genvar gi;
  generate
    for (gi = 0; gi < NWR; gi++) begin : g_wr
      assign wr_dest[gi] = rg_wrt_dest[gi*AW +: AW];
      assign wr_data[gi] = rg_wrt_data[gi*XLEN +: XLEN];
    end
  endgenerate

  // Later ports overwrite earlier ones so the highest index wins; the reserve
  // is applied after the write-clears so a same-cycle reserve keeps busy set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
      busy_reg <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (rg_wrt_en[w] && (wr_dest[w] != '0)) begin
          regs[wr_dest[w]]     <= wr_data[w];
          busy_reg[wr_dest[w]] <= 1'b0;
        end
      end
      if (rsv_en && (rsv_dest != '0)) begin
        busy_reg[rsv_dest] <= 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            bsy;

      assign addr = rg_rd_addr[gi*AW +: AW];

      always_comb begin
        data = regs[addr];
        bsy  = busy_reg[addr];
        if (BYPASS != 0) begin
          for (int w = 0; w < NWR; w++) begin
            if (rg_wrt_en[w] && (wr_dest[w] == addr)) begin
              data = wr_data[w];
              bsy  = 1'b0;
            end
          end
        end
        // r0 is hard-wired: zero data and never busy regardless of forwarding.
        if (addr == '0) begin
          data = '0;
          bsy  = 1'b0;
        end
      end

      assign rg_rd_data[gi*XLEN +: XLEN] = data;
      assign rg_rd_busy[gi]              = bsy;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a forwarding and a non-forwarding instance share stimulus;
// directed vectors from the test plan, then random traffic against an array model.
module tb_reg_file_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wrt_en;
  logic [NWR*AW-1:0]   wrt_dest;
  logic [NWR*XLEN-1:0] wrt_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_dest;
  logic [NRD*XLEN-1:0] data_b, data_n;
  logic [NRD-1:0]      busy_b, busy_n;

  reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .rg_rd_addr(rd_addr), .rg_rd_data(data_b), .rg_rd_busy(busy_b),
    .rg_wrt_en(wrt_en), .rg_wrt_dest(wrt_dest), .rg_wrt_data(wrt_data),
    .rsv_en(rsv_en), .rsv_dest(rsv_dest));

  reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nob (
    .clk(clk), .rst(rst), .rg_rd_addr(rd_addr), .rg_rd_data(data_n), .rg_rd_busy(busy_n),
    .rg_wrt_en(wrt_en), .rg_wrt_dest(wrt_dest), .rg_wrt_data(wrt_data),
    .rsv_en(rsv_en), .rsv_dest(rsv_dest));

  int checks = 0;
  int failures = 0;

  // Architectural model: register contents and busy flags.
  logic [XLEN-1:0] m_reg [NREG];
  bit              m_busy [NREG];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value a read port should show this cycle, from the model plus current inputs.
  function automatic logic [XLEN-1:0] exp_data(input bit byp, input int port);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] r;
    a = rd_addr[port*AW +: AW];
    if (a == 0) return '0;
    r = m_reg[a];
    if (byp)
      for (int w = 0; w < NWR; w++)
        if (wrt_en[w] && wrt_dest[w*AW +: AW] == a) r = wrt_data[w*XLEN +: XLEN];
    return r;
  endfunction

  function automatic logic exp_busy(input bit byp, input int port);
    logic [AW-1:0] a;
    a = rd_addr[port*AW +: AW];
    if (a == 0) return 1'b0;
    if (byp)
      for (int w = 0; w < NWR; w++)
        if (wrt_en[w] && wrt_dest[w*AW +: AW] == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_reg[r] = '0;
        m_busy[r] = 0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wrt_en[w] && wrt_dest[w*AW +: AW] != 0) begin
          m_reg[wrt_dest[w*AW +: AW]] = wrt_data[w*XLEN +: XLEN];
          m_busy[wrt_dest[w*AW +: AW]] = 0;
        end
      end
      if (rsv_en && rsv_dest != 0) m_busy[rsv_dest] = 1;
    end
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit              rst;
    logic [AW-1:0]   a0, a1;
    logic [1:0]      wen;
    logic [AW-1:0]   d0, d1;
    logic [XLEN-1:0] w0, w1;
    bit              rsv;
    logic [AW-1:0]   rd;
    bit              chk;
    logic [XLEN-1:0] e0, e1;     // forwarding instance data, ports 0/1
    logic [1:0]      eb;         // forwarding instance busy {p1,p0}
    logic [XLEN-1:0] n0;         // non-forwarding instance data, port 0
    logic            nb;         // non-forwarding instance busy, port 0
  } vec_t;

  vec_t vec [17];

  initial begin
    rst = 1'b1; rd_addr = '0; wrt_en = '0; wrt_dest = '0; wrt_data = '0;
    rsv_en = 1'b0; rsv_dest = '0;

    //        rst a0 a1 wen   d0 d1 w0            w1            rsv rd chk e0            e1            eb     n0            nb
    vec[0]  = '{1, 4, 1, 2'b00, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        0};
    vec[1]  = '{0, 4, 1, 2'b00, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        2'b00, 32'h0,        0};
    vec[2]  = '{0, 4, 1, 2'b01, 4, 0, 32'h12345678, 32'h0,        0, 0, 1, 32'h12345678, 32'h0,        2'b00, 32'h0,        0};
    vec[3]  = '{0, 4, 1, 2'b00, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h12345678, 32'h0,        2'b00, 32'h12345678, 0};
    vec[4]  = '{0, 0, 0, 2'b01, 0, 0, 32'hDEADBEEF, 32'h0,        1, 0, 1, 32'h0,        32'h0,        2'b00, 32'h0,        0};
    vec[5]  = '{0, 0, 4, 2'b00, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h12345678, 2'b00, 32'h0,        0};
    vec[6]  = '{0, 7, 7, 2'b11, 7, 7, 32'h11111111, 32'h22222222, 0, 0, 1, 32'h22222222, 32'h22222222, 2'b00, 32'h0,        0};
    vec[7]  = '{0, 7, 4, 2'b00, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h22222222, 32'h12345678, 2'b00, 32'h22222222, 0};
    vec[8]  = '{0, 9, 0, 2'b10, 0, 9, 32'h0,        32'hCAFEF00D, 0, 0, 1, 32'hCAFEF00D, 32'h0,        2'b00, 32'h0,        0};
    vec[9]  = '{0, 5, 9, 2'b00, 0, 0, 32'h0,        32'h0,        1, 5, 1, 32'h0,        32'hCAFEF00D, 2'b00, 32'h0,        0};
    vec[10] = '{0, 5, 5, 2'b00, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        2'b11, 32'h0,        1};
    vec[11] = '{0, 5, 1, 2'b01, 5, 0, 32'hA5A5A5A5, 32'h0,        0, 0, 1, 32'hA5A5A5A5, 32'h0,        2'b00, 32'h0,        1};
    vec[12] = '{0, 5, 1, 2'b00, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'hA5A5A5A5, 32'h0,        2'b00, 32'hA5A5A5A5, 0};
    vec[13] = '{0, 5, 1, 2'b01, 5, 0, 32'h5A5A5A5A, 32'h0,        1, 5, 1, 32'h5A5A5A5A, 32'h0,        2'b00, 32'hA5A5A5A5, 0};
    vec[14] = '{0, 5, 5, 2'b00, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h5A5A5A5A, 32'h5A5A5A5A, 2'b11, 32'h5A5A5A5A, 1};
    vec[15] = '{1, 5, 9, 2'b01, 5, 0, 32'h77777777, 32'h0,        1, 9, 1, 32'h77777777, 32'hCAFEF00D, 2'b00, 32'h5A5A5A5A, 1};
    vec[16] = '{0, 5, 9, 2'b00, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        2'b00, 32'h0,        0};

    // Each vector is held for one cycle; outputs are sampled before the edge.
    for (int i = 0; i < 17; i++) begin
      rst      = vec[i].rst;
      rd_addr  = {vec[i].a1, vec[i].a0};
      wrt_en   = vec[i].wen;
      wrt_dest = {vec[i].d1, vec[i].d0};
      wrt_data = {vec[i].w1, vec[i].w0};
      rsv_en   = vec[i].rsv;
      rsv_dest = vec[i].rd;
      @(negedge clk);
      $display("vec %0d: rst=%0d rd=%0d/%0d wen=%b rsv=%0d -> data=%h/%h busy=%b nob=%h/%b",
               i, rst, vec[i].a0, vec[i].a1, wrt_en, rsv_en,
               data_b[31:0], data_b[63:32], busy_b, data_n[31:0], busy_n[0]);
      if (vec[i].chk) begin
        check($sformatf("vec%0d byp_data0", i), data_b[31:0], vec[i].e0);
        check($sformatf("vec%0d byp_data1", i), data_b[63:32], vec[i].e1);
        check($sformatf("vec%0d byp_busy", i), {30'b0, busy_b}, {30'b0, vec[i].eb});
        check($sformatf("vec%0d nob_data0", i), data_n[31:0], vec[i].n0);
        check($sformatf("vec%0d nob_busy0", i), {31'b0, busy_n[0]}, {31'b0, vec[i].nb});
      end
      finish_cycle();
    end

    // Random traffic, addresses mostly in r0..r7 to provoke collisions.
    for (int t = 0; t < 400; t++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int p = 0; p < NRD; p++)
        rd_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      for (int w = 0; w < NWR; w++) begin
        wrt_en[w] = $urandom_range(0, 1);
        wrt_dest[w*AW +: AW] = AW'($urandom_range(0, 7));
        wrt_data[w*XLEN +: XLEN] = $urandom;
      end
      rsv_en = $urandom_range(0, 1);
      rsv_dest = AW'($urandom_range(0, 7));
      @(negedge clk);
      $display("rnd %0d: rst=%0d rd=%h wen=%b dest=%h rsv=%0d/%0d busy=%b/%b",
               t, rst, rd_addr, wrt_en, wrt_dest, rsv_en, rsv_dest, busy_b, busy_n);
      for (int p = 0; p < NRD; p++) begin
        check($sformatf("rnd%0d byp_data%0d", t, p), data_b[p*XLEN +: XLEN], exp_data(1, p));
        check($sformatf("rnd%0d nob_data%0d", t, p), data_n[p*XLEN +: XLEN], exp_data(0, p));
        check($sformatf("rnd%0d byp_busy%0d", t, p), {31'b0, busy_b[p]}, {31'b0, exp_busy(1, p)});
        check($sformatf("rnd%0d nob_busy%0d", t, p), {31'b0, busy_n[p]}, {31'b0, exp_busy(0, p)});
      end
      finish_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file.
- Successor to the single-write, dual-read 32x32 register file.
- Adds configurable width, depth, read-port and write-port counts, optional write-to-read bypass, and a per-register busy scoreboard (reserve at issue, clear at writeback).
- Sits between decode (read/reserve) and writeback (write) in the pipelined core.

Parameters:
XLEN, 32, data width of each register in bits
NREG, 32, number of registers; power of two, >= 2
AW, $clog2(NREG), address width (localparam, derived)
NRD, 2, number of read ports, 1..4
NWR, 2, number of write ports, 1..3
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
rg_rd_addr  in  NRD*AW  read addresses; port i at [i*AW +: AW]
rg_rd_data  out  NRD*XLEN  read data; port i at [i*XLEN +: XLEN]
rg_rd_busy  out  NRD  1 = addressed register has an outstanding reservation
rg_wrt_en  in  NWR  write enable per write port
rg_wrt_dest  in  NWR*AW  write destinations
rg_wrt_data  in  NWR*XLEN  write data
rsv_en  in  1  reserve request (issue of an instruction with a destination)
rsv_dest  in  AW  register to mark busy

Behaviour:
- Reset: synchronous, active-high; only clk and rst named so.
  - rst high at edge: all NREG registers <= 0, all busy bits <= 0.
  - rst overrides any write or reserve in the same cycle.
  - Outputs are combinational from state and inputs; after reset rg_rd_data = 0 and rg_rd_busy = 0 for all ports.
- Register 0:
  - Always reads 0; writes to it are ignored.
  - rsv_en with rsv_dest = 0 is ignored; busy[0] is constant 0.
- Write:
  - At rising edge, for each port w with rg_wrt_en[w] = 1 and dest != 0: reg[dest] <= data.
  - Several ports targeting the same dest in one cycle: highest-indexed port wins.
- Read: combinational, zero-cycle latency.
  - BYPASS = 0: rg_rd_data[i] = reg[addr_i].
  - BYPASS = 1: if any enabled write port targets addr_i (addr_i != 0) this cycle, output that port's data (highest index wins); else reg[addr_i].
- Scoreboard:
  - At edge, rsv_en = 1 and rsv_dest != 0 sets busy[rsv_dest] <= 1.
  - Any enabled write to dest d (d != 0) clears busy[d] <= 0.
  - Reserve and write to the same register in the same cycle: reserve wins, busy stays 1. The new producer is pending; the data update still happens.
  - Reserving an already-busy register: stays 1 (no count; single outstanding producer model).
- rg_rd_busy[i]:
  - = busy[addr_i], except when BYPASS = 1 and a write to addr_i is in flight this cycle; then 0, since data is forwarded.
  - Always 0 for addr_i = 0.
- Out-of-range addresses cannot occur (NREG is a power of two).
- No X propagation: all storage is reset.

Test Plan:
- Reset then read all ports: rst=1 one cycle, rg_rd_addr = {4,1} -> rg_rd_data = {0,0}, rg_rd_busy = {0,0}.
- Basic write/read: port0 writes 0x12345678 to r4, next cycle read r4 and r1 -> 0x12345678 and 0.
- x0 protection: write 0xDEADBEEF to r0 and reserve r0, then read r0 -> data 0, busy 0.
- Write conflict: same cycle port0 writes 0x11111111 to r7 and port1 writes 0x22222222 to r7 -> next cycle r7 = 0x22222222. With BYPASS=1, a same-cycle read of r7 also shows 0x22222222.
- Bypass: write 0xCAFEF00D to r9 while reading r9 -> rg_rd_data = 0xCAFEF00D in that cycle (BYPASS=1); old value 0 (BYPASS=0).
- Scoreboard: reserve r5 -> next cycle busy=1. Write r5 with 0xA5A5A5A5 -> busy 0 after edge. Then reserve and write r5 in the same cycle -> busy remains 1 and r5 = new data. Assert rst mid-sequence -> busy and r5 cleared.
